ball_motion: RTL

Parametrised ball position engine for the brick-breaker datapath; successor to the fixed-width up/down ball counters.
Advances X/Y by configurable steps on each move tick and reflects automatically off the left, right and top walls.
Accepts external bounce requests from the paddle/brick collision logic and reports wall hits and ball loss at the bottom edge.
Feeds the draw/erase FSM and the collision checker; outputs are registered.

---
 rtl/ball_pkg.sv | 19 +
 rtl/ball_motion_axis_stepper.sv | 69 ++++++
 rtl/ball_motion.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// ball_pkg: shared definitions for the ball position engine.
//   state_t         : ball FSM encoding (IDLE / MOVE / LOST)
//   DIR_INC/DIR_DEC : direction encoding (1 = increasing coordinate)
//   SCREEN_X_MAX / SCREEN_Y_MAX : default playfield bounds
package ball_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_LOST = 2'd2
  } state_t;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  localparam int SCREEN_X_MAX = 159;
  localparam int SCREEN_Y_MAX = 119;

endpackage

// File: rtl/ball_motion_axis_stepper.sv
// axis_stepper: combinational next-position / next-direction logic for one
// axis of the ball. The caller owns the registers.
//   i_pos, i_dir   : current position and direction
//   i_step         : step magnitude (0 = hold, no boundary check)
//   i_flip         : collision request to invert direction
//   i_advance      : apply a step this cycle
//   o_pos, o_dir   : next position and direction
//   o_hit_low      : clamped at 0 while moving down-range (reflected)
//   o_hit_high     : clamped at MAX while moving up-range (reflected)
module axis_stepper
  import ball_pkg::*;
#(
  parameter int W   = 8,
  parameter int MAX = 159,
  parameter int SW  = 3
) (
  input  logic [W-1:0]  i_pos,
  input  logic          i_dir,
  input  logic [SW-1:0] i_step,
  input  logic          i_flip,
  input  logic          i_advance,
  output logic [W-1:0]  o_pos,
  output logic          o_dir,
  output logic          o_hit_low,
  output logic          o_hit_high
);

  localparam logic [W:0] MAX_EXT = MAX[W:0];

  logic [W:0] w_pos_ext;
  logic [W:0] w_step_ext;
  logic [W:0] w_sum;

  // One extra bit so the sum can never wrap before the bound compare.
  assign w_pos_ext  = {1'b0, i_pos};
  assign w_step_ext = {{(W+1-SW){1'b0}}, i_step};
  assign w_sum      = w_pos_ext + w_step_ext;

  always_comb begin
    o_pos      = i_pos;
    o_dir      = i_dir;
    o_hit_low  = 1'b0;
    o_hit_high = 1'b0;
    if (i_advance && (i_step != '0)) begin
      if (i_dir == DIR_INC) begin
        if (w_sum >= MAX_EXT) begin
          o_pos      = MAX_EXT[W-1:0];
          o_dir      = DIR_DEC;
          o_hit_high = 1'b1;
        end else begin
          o_pos = w_sum[W-1:0];
        end
      end else begin
        if (w_pos_ext <= w_step_ext) begin
          o_pos     = '0;
          o_dir     = DIR_INC;
          o_hit_low = 1'b1;
        end else begin
          o_pos = i_pos - w_step_ext[W-1:0];
        end
      end
    end
    // A reflection on this edge overrides a simultaneous collision flip.
    if (i_flip && !o_hit_low && !o_hit_high) begin
      o_dir = ~i_dir;
    end
  end

endmodule

// File: rtl/ball_motion.sv
// ball_motion: ball position engine for the brick-breaker datapath.
// Moves X/Y on each tick while in MOVE, reflects off left/right/top walls,
// honours collision flip requests and enters LOST at the bottom edge.
// Optional macro BALL_SPEED_EN adds x_step/y_step inputs; otherwise both
// steps are fixed at 1.
//   clk, reset (sync, active-high)
//   tick, launch, flip_x, flip_y     : control strobes
//   x, y, x_dir, y_dir               : registered ball state
//   moving, wall_hit, lost           : registered status / one-cycle pulses
//   x_step, y_step (BALL_SPEED_EN)   : per-tick step sizes
module ball_motion
  import ball_pkg::*;
#(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int X_MAX  = SCREEN_X_MAX,
  parameter int Y_MAX  = SCREEN_Y_MAX,
  parameter int X_INIT = 80,
  parameter int Y_INIT = 100,
  parameter int STEP_W = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           launch,
  input  logic           flip_x,
  input  logic           flip_y,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           x_dir,
  output logic           y_dir,
  output logic           moving,
  output logic           wall_hit,
  output logic           lost
`ifdef BALL_SPEED_EN
  ,
  input  logic [STEP_W-1:0] x_step,
  input  logic [STEP_W-1:0] y_step
`endif
);

  localparam logic [X_W-1:0] X_INIT_V = X_INIT[X_W-1:0];
  localparam logic [Y_W-1:0] Y_INIT_V = Y_INIT[Y_W-1:0];

  state_t          r_state, w_state_nxt;
  logic            w_serve;
  logic [X_W-1:0]  r_x, w_x_pos;
  logic [Y_W-1:0]  r_y, w_y_pos;
  logic            r_x_dir, r_y_dir, w_x_dir, w_y_dir;
  logic            r_moving, r_wall_hit, r_lost;
  logic            w_x_lo, w_x_hi, w_y_lo, w_y_hi;
  logic            w_in_move, w_adv, w_flip_x, w_flip_y;
  logic [STEP_W-1:0] w_sx, w_sy;

`ifdef BALL_SPEED_EN
  assign w_sx = x_step;
  assign w_sy = y_step;
`else
  assign w_sx = STEP_W'(1);
  assign w_sy = STEP_W'(1);
`endif

  assign w_in_move = (r_state == ST_MOVE);
  assign w_adv     = w_in_move && tick;
  assign w_flip_x  = w_in_move && flip_x;
  assign w_flip_y  = w_in_move && flip_y;

  axis_stepper #(.W(X_W), .MAX(X_MAX), .SW(STEP_W)) u_x_axis (
    .i_pos(r_x), .i_dir(r_x_dir), .i_step(w_sx), .i_flip(w_flip_x),
    .i_advance(w_adv), .o_pos(w_x_pos), .o_dir(w_x_dir),
    .o_hit_low(w_x_lo), .o_hit_high(w_x_hi)
  );

  axis_stepper #(.W(Y_W), .MAX(Y_MAX), .SW(STEP_W)) u_y_axis (
    .i_pos(r_y), .i_dir(r_y_dir), .i_step(w_sy), .i_flip(w_flip_y),
    .i_advance(w_adv), .o_pos(w_y_pos), .o_dir(w_y_dir),
    .o_hit_low(w_y_lo), .o_hit_high(w_y_hi)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_serve     = 1'b0;
    case (r_state)
      ST_IDLE: if (launch) w_state_nxt = ST_MOVE;
      ST_MOVE: if (w_y_hi) w_state_nxt = ST_LOST;
      ST_LOST: begin
        if (launch) begin
          w_state_nxt = ST_MOVE;
          w_serve     = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset || w_serve) begin
      r_x     <= X_INIT_V;
      r_y     <= Y_INIT_V;
      r_x_dir <= DIR_INC;
      r_y_dir <= DIR_DEC;
    end else if (w_in_move) begin
      r_x     <= w_x_pos;
      r_y     <= w_y_pos;
      r_x_dir <= w_x_dir;
      // The bottom edge is a loss, not a reflection: keep the direction
      // (plus any flip) instead of the stepper's reflected one.
      r_y_dir <= w_y_hi ? (r_y_dir ^ w_flip_y) : w_y_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_moving   <= 1'b0;
      r_wall_hit <= 1'b0;
      r_lost     <= 1'b0;
    end else begin
      r_moving   <= (w_state_nxt == ST_MOVE);
      r_wall_hit <= w_x_lo | w_x_hi | w_y_lo;
      r_lost     <= w_y_hi;
    end
  end

  assign x        = r_x;
  assign y        = r_y;
  assign x_dir    = r_x_dir;
  assign y_dir    = r_y_dir;
  assign moving   = r_moving;
  assign wall_hit = r_wall_hit;
  assign lost     = r_lost;

endmodule
